// File: rtl/slow_clk_monitor.sv
// Measures high/low phase lengths of a slow clock sampled in the clk domain and declares lock on a stable ratio.
// Optional SLOW_CLK_MON_EXPECT_EN adds a static expected_period that lock must also agree with.
module slow_clk_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_COUNT  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       slow_clk,
`ifdef SLOW_CLK_MON_EXPECT_EN
   input  logic [8:0] expected_period,
`endif
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [7:0] high_cnt,
   output logic [7:0] low_cnt,
   output logic [8:0] period,
   output logic       locked,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   dly_lvl;
   logic                   sync_lvl;
   logic                   rise_det;
   logic                   fall_det;
   logic                   edge_det;
   logic [7:0]             cnt;
   logic                   cnt_sat;
   logic [3:0]             match_cnt;
   logic [3:0]             match_nxt;
   logic [1:0]             valid;      // [1]: low_cnt holds a capture, [0]: high_cnt does
   logic                   pol_valid;
   logic                   same_val;
   logic                   period_ok;
   logic                   period_bad;

   assign sync_lvl  = sync_pipe[SYNC_STAGES-1];
   assign rise_det  = sync_lvl & ~dly_lvl;
   assign fall_det  = ~sync_lvl & dly_lvl;
   assign edge_det  = rise_det | fall_det;
   assign cnt_sat   = (cnt == 8'd255);
   assign pol_valid = rise_det ? valid[1] : valid[0];
   assign same_val  = rise_det ? (cnt == low_cnt) : (cnt == high_cnt);
   assign match_nxt = (match_cnt >= 4'(LOCK_COUNT)) ? match_cnt : match_cnt + 4'd1;

`ifdef SLOW_CLK_MON_EXPECT_EN
   // period lags a capture by one cycle, so it is compared one cycle after that
   logic cap_q;
   logic per_chk;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q   <= 1'b0;
         per_chk <= 1'b0;
      end else begin
         cap_q   <= edge_det & (state != IDLE);
         per_chk <= cap_q;
      end
   end

   assign period_ok  = (period == expected_period);
   assign period_bad = per_chk & ~period_ok;
`else
   assign period_ok  = 1'b1;
   assign period_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_pipe  <= '0;
         dly_lvl    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         cnt        <= 8'd0;
         period     <= 9'd0;
      end else begin
         sync_pipe  <= {sync_pipe[SYNC_STAGES-2:0], slow_clk};
         dly_lvl    <= sync_lvl;
         rise_pulse <= rise_det;
         fall_pulse <= fall_det;
         period     <= {1'b0, high_cnt} + {1'b0, low_cnt};
         if (edge_det)
            cnt <= 8'd1;
         else if (!cnt_sat)
            cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         locked    <= 1'b0;
         err       <= 1'b0;
         match_cnt <= 4'd0;
         valid     <= 2'b00;
         high_cnt  <= 8'd0;
         low_cnt   <= 8'd0;
      end else begin
         err <= 1'b0;
         if (edge_det && state != IDLE) begin
            if (rise_det)
               low_cnt <= cnt;
            else
               high_cnt <= cnt;
         end
         case (state)
            IDLE: begin
               if (edge_det) begin
                  state     <= ACQUIRE;
                  valid     <= 2'b00;
                  match_cnt <= 4'd0;
               end
            end
            ACQUIRE: begin
               if (edge_det) begin
                  if (rise_det)
                     valid[1] <= 1'b1;
                  else
                     valid[0] <= 1'b1;
                  if (pol_valid && same_val) begin
                     match_cnt <= match_nxt;
                     if (match_nxt == 4'(LOCK_COUNT) && period_ok) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     match_cnt <= 4'd0;
                  end
               end else if (cnt_sat) begin
                  state <= IDLE;
               end
            end
            LOCKED: begin
               if ((edge_det && !same_val) || period_bad) begin
                  state     <= ACQUIRE;
                  locked    <= 1'b0;
                  err       <= 1'b1;
                  match_cnt <= 4'd0;
               end else if (!edge_det && cnt_sat) begin
                  state  <= IDLE;
                  locked <= 1'b0;
                  err    <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Directed bench for slow_clk_monitor: lock at several ratios, saturation, relock on ratio change, async reset.
module tb_slow_clk_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       slow_clk = 1'b0;
   logic       rise_pulse, fall_pulse, locked, err;
   logic [7:0] high_cnt, low_cnt;
   logic [8:0] period;
`ifdef SLOW_CLK_MON_EXPECT_EN
   logic [8:0] expected_period = 9'd4;
`endif

   int n_chk = 0, n_err = 0;
   int hi_len = 2, lo_len = 2, ph_left = 0;
   bit run = 1'b0;
   int cyc = 0, last_rise = 0, rise_int = 0, last_edge = 0, err_cyc = 0, err_cnt = 0;

   slow_clk_monitor #(.SYNC_STAGES(2), .LOCK_COUNT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .slow_clk   (slow_clk),
`ifdef SLOW_CLK_MON_EXPECT_EN
      .expected_period (expected_period),
`endif
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .high_cnt   (high_cnt),
      .low_cnt    (low_cnt),
      .period     (period),
      .locked     (locked),
      .err        (err)
   );

   always #5 clk = ~clk;

   // slow clock: hi_len cycles high, lo_len cycles low, changed on falling clk
   always @(negedge clk) begin
      if (run) begin
         if (ph_left == 0) begin
            slow_clk = ~slow_clk;
            ph_left  = slow_clk ? hi_len : lo_len;
         end
         ph_left = ph_left - 1;
      end
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rise_pulse) begin
         rise_int  = cyc - last_rise;
         last_rise = cyc;
      end
      if (rise_pulse || fall_pulse) last_edge = cyc;
      if (err) begin
         err_cnt = err_cnt + 1;
         err_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_lock(input string tag, input int budget);
      int i;
      i = 0;
      while (i < budget && locked !== 1'b1) begin
         cycles(1);
         i = i + 1;
      end
      chk(tag, int'(locked), 1);
   endtask

   task automatic wait_err(input string tag, input int budget);
      int i, base;
      base = err_cnt;
      i = 0;
      while (i < budget && err_cnt == base) begin
         cycles(1);
         i = i + 1;
      end
      chk(tag, err_cnt - base, 1);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_rise"},   int'(rise_pulse), 0);
      chk({pfx, "_fall"},   int'(fall_pulse), 0);
      chk({pfx, "_high"},   int'(high_cnt), 0);
      chk({pfx, "_low"},    int'(low_cnt), 0);
      chk({pfx, "_period"}, int'(period), 0);
      chk({pfx, "_locked"}, int'(locked), 0);
      chk({pfx, "_err"},    int'(err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cycles(3);
      chk_zero("rst");

      // 2/2 lock
      reset = 1'b1;
      run   = 1'b1;
      wait_lock("lock_2_2", 200);
      cycles(12);
      chk("hi_2_2", int'(high_cnt), 2);
      chk("lo_2_2", int'(low_cnt), 2);
      chk("per_2_2", int'(period), 4);
      chk("rise_int_2_2", rise_int, 4);
      chk("still_locked_2_2", int'(locked), 1);
      chk("no_err_2_2", err_cnt, 0);

      // frozen slow clock -> saturation
      run = 1'b0;
      wait_err("sat_err", 400);
      chk("sat_gap", err_cyc - last_edge, 255);
      cycles(3);
      chk("sat_locked", int'(locked), 0);
      chk("sat_period", int'(period), 4);
      chk("sat_single_err", err_cnt, 1);

      // 3/2 from idle, no err expected
`ifdef SLOW_CLK_MON_EXPECT_EN
      expected_period = 9'd5;
`endif
      hi_len = 3;
      lo_len = 2;
      run    = 1'b1;
      wait_lock("lock_3_2", 200);
      cycles(15);
      chk("hi_3_2", int'(high_cnt), 3);
      chk("lo_3_2", int'(low_cnt), 2);
      chk("per_3_2", int'(period), 5);
      chk("rise_int_3_2", rise_int, 5);
      chk("err_3_2", err_cnt, 1);

      // locked 3/2 -> 2/2
`ifdef SLOW_CLK_MON_EXPECT_EN
      expected_period = 9'd4;
`endif
      hi_len = 2;
      lo_len = 2;
      wait_err("mis_err_2_2", 100);
      chk("mis_unlock_2_2", int'(locked), 0);
      wait_lock("relock_2_2", 200);
      cycles(12);
      chk("relock_per_2_2", int'(period), 4);
      chk("relock_err_2_2", err_cnt, 2);

      // locked 2/2 -> 3/3
`ifdef SLOW_CLK_MON_EXPECT_EN
      expected_period = 9'd6;
`endif
      hi_len = 3;
      lo_len = 3;
      wait_err("mis_err_3_3", 100);
      chk("mis_unlock_3_3", int'(locked), 0);
      wait_lock("relock_3_3", 200);
      cycles(15);
      chk("hi_3_3", int'(high_cnt), 3);
      chk("lo_3_3", int'(low_cnt), 3);
      chk("per_3_3", int'(period), 6);
      chk("err_3_3", err_cnt, 3);

      // async reset while locked, then relock at 2/2
      @(posedge clk);
      #3 reset = 1'b0;
      #1 chk_zero("arst");
`ifdef SLOW_CLK_MON_EXPECT_EN
      expected_period = 9'd4;
`endif
      hi_len = 2;
      lo_len = 2;
      cycles(4);
      reset = 1'b1;
      wait_lock("rst_relock", 200);
      cycles(12);
      chk("rst_relock_per", int'(period), 4);
      chk("rst_relock_err", err_cnt, 3);

`ifdef SLOW_CLK_MON_EXPECT_EN
      // wrong expected period blocks lock
      reset = 1'b0;
      expected_period = 9'd5;
      cycles(2);
      reset = 1'b1;
      cycles(100);
      chk("exp5_locked", int'(locked), 0);
      chk("exp5_period", int'(period), 4);
      reset = 1'b0;
      expected_period = 9'd4;
      cycles(2);
      reset = 1'b1;
      wait_lock("exp4_lock", 200);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
